// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_accumulator_pkg;

    // Default frame-length field width and accumulator width.
    localparam int LEN_W_DEF = 8;
    localparam int ACC_W_DEF = 16;

    // Frame FSM states. Encodings are fixed so a debug probe of the state bits
    // can be read without knowing the enum.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/mac_accumulator_acc_add.sv
// acc_add: ACC_W-bit adder of a wide operand and a zero-extended 8-bit sample, with carry-out.
// Latency: purely combinational.
// Backpressure: none; it has no handshake.
// Ports: a_i (accumulator), b_i (8-bit sample), sum_o (a+b mod 2^ACC_W), carry_o (carry out of ACC_W).
module acc_add #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [7:0]       b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    // One extra bit on the left captures the carry; the sample is padded up to
    // ACC_W+1 bits so both operands have matching widths.
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {{(ACC_W - 7){1'b0}}, b_i};
    assign sum_o    = full_sum[ACC_W-1:0];
    assign carry_o  = full_sum[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmable-length frame of 8-bit samples into a wide result.
// Latency: sum_valid rises on the edge after the final accepted sample (1 cycle).
// Backpressure: in_ready is high only while accumulating; the result is held in HOLD until out_ready.
// Ports: ck/rst_n (sync active-low reset); start/len begin a frame; in_valid/in_data/in_ready
//        sample input; sum_valid/sum/overflow/out_ready result output; busy and count status.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             sum_valid,
    output logic [ACC_W-1:0] sum,
    output logic             overflow,
    output logic             busy,
    output logic [LEN_W-1:0] count
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;
    logic [LEN_W-1:0]   count_inc;

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .a_i     (acc_q),
        .b_i     (in_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // in_ready depends on state only, so there is no combinational path from
    // in_valid back to in_ready.
    assign in_ready  = (state_q == S_ACCUM);
    assign sum_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign sum       = acc_q;
    assign overflow  = ovf_q;
    assign count     = count_q;

    assign accept    = in_valid & in_ready;
    assign count_inc = count_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        len_d   = len_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    len_d   = len;
                    // A zero-length frame skips accumulation and presents a zero result.
                    state_d = (len == '0) ? S_HOLD : S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (accept) begin
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_carry;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator: a 16-bit and a 10-bit accumulator share one stimulus stream.
// Latency: expected results are queued at frame start and popped when sum_valid rises.
// Backpressure: out_ready is driven by the bench, including stalls in HOLD.
module tb_mac_accumulator;
    import mac_accumulator_pkg::*;

    localparam int LW = LEN_W_DEF;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_ready;

    logic                 in_ready_a, sum_valid_a, overflow_a, busy_a;
    logic [ACC_W_DEF-1:0] sum_a;
    logic [LW-1:0]        count_a;

    logic          in_ready_b, sum_valid_b, overflow_b, busy_b;
    logic [9:0]    sum_b;
    logic [LW-1:0] count_b;

    mac_accumulator u_dut16 (
        .ck        (ck),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_a),
        .out_ready (out_ready),
        .sum_valid (sum_valid_a),
        .sum       (sum_a),
        .overflow  (overflow_a),
        .busy      (busy_a),
        .count     (count_a)
    );

    mac_accumulator #(.LEN_W(LW), .ACC_W(10)) u_dut10 (
        .ck        (ck),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_b),
        .out_ready (out_ready),
        .sum_valid (sum_valid_b),
        .sum       (sum_b),
        .overflow  (overflow_b),
        .busy      (busy_b),
        .count     (count_b)
    );

    // Expected frame result as plain integers; each DUT width is derived at compare time.
    typedef struct {
        int total;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic push_exp(input int total, input int cnt);
        exp_t e;
        e.total = total;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    task automatic start_frame(input int l);
        start = 1'b1;
        len   = LW'(l);
        step();
        start = 1'b0;
    endtask

    task automatic send_sample(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        step();
        in_valid = 1'b0;
    endtask

    // Waits for a frame result, compares both DUTs against the queued model,
    // then completes the handshake and checks the return to IDLE.
    task automatic collect(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ck);
            if (sum_valid_a === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: sum_valid got 0 for 20 cycles, want 1", tag);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard: got a result, want no result (queue empty)", tag);
            return;
        end
        e = sb.pop_front();

        n_vec++;
        if (sum_a !== 16'(e.total)) begin
            n_err++;
            $display("FAIL %s sum16: got %0d, want %0d", tag, sum_a, 16'(e.total));
        end
        n_vec++;
        if (overflow_a !== (e.total >= 65536)) begin
            n_err++;
            $display("FAIL %s ovf16: got %0b, want %0b", tag, overflow_a, (e.total >= 65536));
        end
        n_vec++;
        if (count_a !== LW'(e.cnt)) begin
            n_err++;
            $display("FAIL %s count: got %0d, want %0d", tag, count_a, e.cnt);
        end
        n_vec++;
        if (sum_valid_b !== 1'b1) begin
            n_err++;
            $display("FAIL %s valid10: got %0b, want 1", tag, sum_valid_b);
        end
        n_vec++;
        if (sum_b !== 10'(e.total)) begin
            n_err++;
            $display("FAIL %s sum10: got %0d, want %0d", tag, sum_b, 10'(e.total));
        end
        n_vec++;
        if (overflow_b !== (e.total >= 1024)) begin
            n_err++;
            $display("FAIL %s ovf10: got %0b, want %0b", tag, overflow_b, (e.total >= 1024));
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge ck);
        n_vec++;
        if ({sum_valid_a, busy_a, in_ready_a} !== 3'b000) begin
            n_err++;
            $display("FAIL %s idle: got valid/busy/rdy %0b%0b%0b, want 000",
                     tag, sum_valid_a, busy_a, in_ready_a);
        end
        n_vec++;
        if (sum_a !== 16'(e.total)) begin
            n_err++;
            $display("FAIL %s sum_in_idle: got %0d, want %0d", tag, sum_a, 16'(e.total));
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b1;
        len       = LW'(3);
        in_valid  = 1'b1;
        in_data   = 8'd55;
        out_ready = 1'b1;
        step();
        step();
        @(negedge ck);
        n_vec++;
        if ({sum_valid_a, in_ready_a, busy_a, overflow_a} !== 4'b0000 || sum_a !== '0 || count_a !== '0) begin
            n_err++;
            $display("FAIL reset_a: got v%0b r%0b b%0b o%0b sum %0d cnt %0d, want all 0",
                     sum_valid_a, in_ready_a, busy_a, overflow_a, sum_a, count_a);
        end
        n_vec++;
        if ({sum_valid_b, in_ready_b, busy_b, overflow_b} !== 4'b0000 || sum_b !== '0 || count_b !== '0) begin
            n_err++;
            $display("FAIL reset_b: got v%0b r%0b b%0b o%0b sum %0d cnt %0d, want all 0",
                     sum_valid_b, in_ready_b, busy_b, overflow_b, sum_b, count_b);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        step();
        @(negedge ck);
        n_vec++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy %0b rdy %0b, want 0 0", busy_a, in_ready_a);
        end
    endtask

    task automatic test_basic();
        int d[4];
        d = '{10, 20, 30, 40};
        push_exp(100, 4);
        start_frame(4);
        n_vec++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL basic_accum: got busy %0b rdy %0b, want 1 1", busy_a, in_ready_a);
        end
        for (int i = 0; i < 4; i++) begin
            send_sample(d[i]);
            @(negedge ck);
            n_vec++;
            if (count_a !== LW'(i + 1) || sum_valid_a !== (i == 3)) begin
                n_err++;
                $display("FAIL basic_step%0d: got count %0d valid %0b, want %0d %0b",
                         i, count_a, sum_valid_a, i + 1, (i == 3));
            end
        end
        collect("basic");
    endtask

    task automatic test_bubbles();
        int v[6];
        int d[6];
        int c[6];
        v = '{1, 0, 0, 1, 0, 1};
        d = '{5, 99, 123, 7, 200, 9};
        c = '{1, 1, 1, 2, 2, 3};
        push_exp(21, 3);
        start_frame(3);
        for (int i = 0; i < 6; i++) begin
            in_valid = v[i][0];
            in_data  = 8'(d[i]);
            step();
            @(negedge ck);
            n_vec++;
            if (count_a !== LW'(c[i])) begin
                n_err++;
                $display("FAIL bubbles_count%0d: got %0d, want %0d", i, count_a, c[i]);
            end
        end
        in_valid = 1'b0;
        collect("bubbles");
    endtask

    task automatic test_overflow();
        push_exp(1275, 5);
        start_frame(5);
        for (int i = 0; i < 5; i++) send_sample(255);
        collect("overflow");
        push_exp(3, 1);
        start_frame(1);
        send_sample(3);
        collect("after_overflow");
    endtask

    task automatic test_empty_backpressure();
        push_exp(0, 0);
        start_frame(0);
        @(negedge ck);
        n_vec++;
        if (sum_valid_a !== 1'b1 || sum_a !== '0) begin
            n_err++;
            $display("FAIL empty_hold: got valid %0b sum %0d, want 1 0", sum_valid_a, sum_a);
        end
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            len       = LW'(5);
            in_valid  = 1'b1;
            in_data   = 8'd77;
            step();
            @(negedge ck);
            n_vec++;
            if (sum_valid_a !== 1'b1 || in_ready_a !== 1'b0 || sum_a !== '0 || count_a !== '0) begin
                n_err++;
                $display("FAIL stall%0d: got valid %0b rdy %0b sum %0d cnt %0d, want 1 0 0 0",
                         i, sum_valid_a, in_ready_a, sum_a, count_a);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        collect("empty");
    endtask

    task automatic test_reset_midframe();
        start_frame(4);
        send_sample(50);
        send_sample(60);
        @(negedge ck);
        n_vec++;
        if (count_a !== LW'(2) || sum_a !== 16'd110) begin
            n_err++;
            $display("FAIL midframe_partial: got cnt %0d sum %0d, want 2 110", count_a, sum_a);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge ck);
        n_vec++;
        if ({sum_valid_a, in_ready_a, busy_a, overflow_a} !== 4'b0000 || sum_a !== '0 || count_a !== '0) begin
            n_err++;
            $display("FAIL midframe_reset: got v%0b r%0b b%0b o%0b sum %0d cnt %0d, want all 0",
                     sum_valid_a, in_ready_a, busy_a, overflow_a, sum_a, count_a);
        end
        push_exp(8, 1);
        start_frame(1);
        send_sample(8);
        collect("post_reset");
    endtask

    task automatic test_start_busy();
        push_exp(3, 2);
        start_frame(2);
        send_sample(1);
        start = 1'b1;
        len   = LW'(7);
        step();
        start = 1'b0;
        @(negedge ck);
        n_vec++;
        if (count_a !== LW'(1) || sum_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start: got cnt %0d valid %0b busy %0b, want 1 0 1",
                     count_a, sum_valid_a, busy_a);
        end
        send_sample(2);
        @(negedge ck);
        n_vec++;
        if (sum_valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL busy_end: got valid %0b after 2 accepts, want 1", sum_valid_a);
        end
        collect("start_busy");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_overflow();
        test_empty_backpressure();
        test_reset_midframe();
        test_start_busy();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending results, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
